// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared types and constants for the data-memory responder.
//   - state_e          : responder FSM states (IDLE, BUSY, RESP)
//   - DMEM_* defaults   : default parameter values for dmem_responder
//   - strb_w / idx_w    : derive strobe width and word-index width
//   - latency_ok        : legal LATENCY range check (1..255, fits the 8-bit counter)
// Optional feature macro used by dmem_responder: DMEM_ERR_CHECK_EN
// -----------------------------------------------------------------------------
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int DMEM_ADDR_W      = 32;
  localparam int DMEM_DATA_W      = 32;
  localparam int DMEM_DEPTH_WORDS = 1024;
  localparam int DMEM_LATENCY     = 4;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 255;

  // Byte-lane count for a given data width.
  function automatic int strb_w(input int data_w);
    return data_w / 8;
  endfunction

  // Word-index width for a power-of-two storage depth.
  function automatic int idx_w(input int depth_words);
    return $clog2(depth_words);
  endfunction

  localparam int DMEM_STRB_W = strb_w(DMEM_DATA_W);
  localparam int DMEM_IDX_W  = idx_w(DMEM_DEPTH_WORDS);

  // True when the latency fits the 8-bit down-counter and is non-zero.
  function automatic bit latency_ok(input int lat);
    return (lat >= LAT_MIN) && (lat <= LAT_MAX);
  endfunction

endpackage

// File: rtl/dmem_latency_counter.sv
// -----------------------------------------------------------------------------
// dmem_latency_counter
// Loadable 8-bit down-counter. Loads load_val_i when load_i is high, otherwise
// decrements once per edge until it reaches zero and then holds.
// Ports:
//   clk_i       in  1  clock, rising edge
//   rst_ni      in  1  asynchronous active-low reset (count -> 0)
//   load_i      in  1  load the counter
//   load_val_i  in  8  value to load
//   last_o      out 1  high while the count equals 1
// -----------------------------------------------------------------------------
module dmem_latency_counter (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  output logic       last_o
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Next count: load has priority, otherwise count down and saturate at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == 8'd1);

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Data-memory responder for the CPU load/store port. Accepts one request at a
// time, waits LATENCY edges, performs the access and presents a response that
// is held until the requester takes it.
// Ports:
//   clk         in  1         clock, rising edge
//   reset_n     in  1         asynchronous active-low reset
//   req_valid   in  1         request present
//   req_ready   out 1         accepting requests (IDLE only)
//   req_write   in  1         1 = store, 0 = load
//   req_addr    in  ADDR_W    byte address
//   req_wdata   in  DATA_W    store data
//   req_wstrb   in  DATA_W/8  store byte-lane enables
//   resp_valid  out 1         response present
//   resp_ready  in  1         requester takes response
//   resp_rdata  out DATA_W    load data (0 for stores and faulted requests)
//   resp_err    out 1         request faulted
// Optional feature: define DMEM_ERR_CHECK_EN to flag misaligned and
// out-of-range addresses; otherwise addresses alias and resp_err is 0.
// -----------------------------------------------------------------------------
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = DMEM_ADDR_W,
  parameter int DATA_W      = DMEM_DATA_W,
  parameter int DEPTH_WORDS = DMEM_DEPTH_WORDS,
  parameter int LATENCY     = DMEM_LATENCY
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err
);

  localparam int STRB_W = strb_w(DATA_W);
  localparam int IDX_W  = idx_w(DEPTH_WORDS);

  if (!latency_ok(LATENCY)) begin : g_latency_check
    $error("dmem_responder: LATENCY must be in 1..255");
  end

  state_e              state_q;
  logic                req_ready_q;
  logic                resp_valid_q;
  logic [DATA_W-1:0]   resp_rdata_q;
  logic                resp_err_q;
  logic                write_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic [DATA_W-1:0]   mem_q [DEPTH_WORDS];

  logic [IDX_W-1:0]    idx_s;
  logic                fault_s;
  logic                load_s;
  logic                last_s;
  logic                commit_s;
  logic [DATA_W-1:0]   merged_d;

  assign idx_s  = addr_q[IDX_W+1:2];
  assign load_s = (state_q == IDLE) && req_valid && req_ready_q;

`ifdef DMEM_ERR_CHECK_EN
  // Any address bit above the word index means the byte address is beyond the array.
  assign fault_s = (addr_q[1:0] != 2'b00) || (|(addr_q >> (IDX_W + 2)));
`else
  logic unused_addr_s;
  assign fault_s       = 1'b0;
  assign unused_addr_s = ^{addr_q[1:0], addr_q[ADDR_W-1:IDX_W+2]};
`endif

  // Store commits on the final BUSY edge; an async reset forces IDLE, so an aborted store never commits.
  assign commit_s = (state_q == BUSY) && last_s && write_q && !fault_s;

  dmem_latency_counter u_lat_cnt (
    .clk_i      (clk),
    .rst_ni     (reset_n),
    .load_i     (load_s),
    .load_val_i (8'(LATENCY)),
    .last_o     (last_s)
  );

  // Merge the enabled store byte lanes into the current word.
  always_comb begin
    merged_d = mem_q[idx_s];
    for (int b = 0; b < STRB_W; b++) begin
      if (wstrb_q[b]) begin
        merged_d[b*8 +: 8] = wdata_q[b*8 +: 8];
      end else begin
        merged_d[b*8 +: 8] = mem_q[idx_s][b*8 +: 8];
      end
    end
  end

  // Storage array; contents survive reset.
  always_ff @(posedge clk) begin
    if (commit_s) begin
      mem_q[idx_s] <= merged_d;
    end
  end

  // Responder FSM with registered handshake and response outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_s) begin
            write_q     <= req_write;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            wstrb_q     <= req_wstrb;
            req_ready_q <= 1'b0;
            state_q     <= BUSY;
          end
        end
        BUSY: begin
          if (last_s) begin
            resp_valid_q <= 1'b1;
            resp_err_q   <= fault_s;
            resp_rdata_q <= (write_q || fault_s) ? '0 : mem_q[idx_s];
            state_q      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: begin
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Scoreboard bench for dmem_responder (LATENCY=4, DEPTH_WORDS=1024). The driver
// pushes the hand-computed response for each accepted request; a negedge
// monitor checks latency, held response during backpressure and the values
// at each handshake. Works with or without DMEM_ERR_CHECK_EN.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [3:0]  req_wstrb = 4'd0;
  logic        resp_ready = 1'b1;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t sb_q[$];

  dmem_responder #(
    .ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(1024), .LATENCY(LAT)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor: checks every cycle a response is presented.
  logic prev_valid = 1'b0;
  bit   hs_pending = 1'b0;
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_valid = 1'b0;
      hs_pending = 1'b0;
    end else begin
      if (hs_pending) begin
        check1("idle_after_hs_valid", resp_valid, 1'b0);
        check1("idle_after_hs_ready", req_ready, 1'b1);
        hs_pending = 1'b0;
      end
      if (resp_valid) begin
        if (sb_q.size() == 0) begin
          fail_now("unexpected_resp");
        end else begin
          if (!prev_valid) check32("latency", 32'(cyc - sb_q[0].acc), 32'(LAT));
          check1("req_ready_in_resp", req_ready, 1'b0);
          if (resp_ready) begin
            check32("resp_rdata", resp_rdata, sb_q[0].rdata);
            check1("resp_err", resp_err, sb_q[0].err);
            void'(sb_q.pop_front());
            hs_pending = 1'b1;
          end else begin
            check32("stall_rdata", resp_rdata, sb_q[0].rdata);
            check1("stall_err", resp_err, sb_q[0].err);
          end
        end
      end
      prev_valid = resp_valid;
    end
  end

  // Issue one request; push the expected response when it will be accepted.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [31:0] exp_rd,
                        input logic exp_err, input bit expect_resp);
    bit done = 1'b0;
    int tries = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_wstrb = s;
    while (!done && tries < 100) begin
      if (req_ready) begin
        if (expect_resp) sb_q.push_back('{rdata: exp_rd, err: exp_err, acc: cyc + 1});
        done = 1'b1;
      end
      @(posedge clk); #1;
      tries++;
    end
    req_valid = 1'b0;
    if (!done) fail_now("req_accept_timeout");
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      fail_now("drain_timeout");
      sb_q.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    // 1. Reset
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check1("rst_req_ready", req_ready, 1'b1);
    check1("rst_resp_valid", resp_valid, 1'b0);
    check32("rst_resp_rdata", resp_rdata, 32'h0);
    check1("rst_resp_err", resp_err, 1'b0);

    // 2. Store/load round trip
    do_req(1'b1, 32'h40, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 1'b1);
    do_req(1'b0, 32'h40, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 1'b1);
    // 3. Byte strobe, then an all-zero strobe that must not write
    do_req(1'b1, 32'h40, 32'h0000AA00, 4'b0010, 32'h0, 1'b0, 1'b1);
    do_req(1'b0, 32'h40, 32'h0, 4'h0, 32'hDEADAAEF, 1'b0, 1'b1);
    do_req(1'b1, 32'h40, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0, 1'b1);
    do_req(1'b0, 32'h40, 32'h0, 4'h0, 32'hDEADAAEF, 1'b0, 1'b1);
    do_req(1'b1, 32'h0, 32'h11223344, 4'hF, 32'h0, 1'b0, 1'b1);
    drain();

    // 4. Backpressure: hold resp_ready low 3 cycles in RESP
    resp_ready = 1'b0;
    do_req(1'b0, 32'h0, 32'h0, 4'h0, 32'h11223344, 1'b0, 1'b1);
    begin
      int n = 0;
      while (!resp_valid && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      if (!resp_valid) fail_now("bp_resp_timeout");
    end
    repeat (3) begin @(posedge clk); #1; end
    resp_ready = 1'b1;
    drain();

    // 5. Error path / aliasing
`ifdef DMEM_ERR_CHECK_EN
    do_req(1'b0, 32'h42, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1);
    do_req(1'b1, 32'h1000, 32'hBADBAD00, 4'hF, 32'h0, 1'b1, 1'b1);
    do_req(1'b0, 32'h0, 32'h0, 4'h0, 32'h11223344, 1'b0, 1'b1);
    do_req(1'b0, 32'h1000, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1);
`else
    do_req(1'b0, 32'h1000, 32'h0, 4'h0, 32'h11223344, 1'b0, 1'b1);
    do_req(1'b0, 32'h42, 32'h0, 4'h0, 32'hDEADAAEF, 1'b0, 1'b1);
`endif
    drain();

    // 6. Reset mid-operation aborts an uncommitted store
    do_req(1'b1, 32'h80, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, 1'b1);
    drain();
    do_req(1'b1, 32'h80, 32'h12345678, 4'hF, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk); #1;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      check1("abort_no_resp", resp_valid, 1'b0);
    end
    check1("abort_req_ready", req_ready, 1'b1);
    do_req(1'b0, 32'h80, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
